// File: rtl/decimal_entry_accumulator_pkg.sv
// rtl/decimal_entry_accumulator_pkg.sv - shared constants and FSM encoding for decimal entry
// Purpose: sizes of the digit buffer and binary result, legal digit limit, FSM states.
package decimal_entry_accumulator_pkg;

  localparam int MAX_DIGITS = 6;
  localparam int DIGIT_W    = 4;
  localparam int VALUE_W    = 40;
  localparam int BUF_W      = MAX_DIGITS * DIGIT_W;
  localparam int CNT_W      = 3;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/decimal_entry_accumulator_bcd_to_bin_serial.sv
// rtl/decimal_entry_accumulator_bcd_to_bin_serial.sv - serial BCD to binary converter
// Purpose: one decimal digit per clock, most significant first, acc = acc*10 + digit.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        load bcd_i into the shift copy and zero the accumulator
//   clear_i        abort a running conversion
//   bcd_i          BCD buffer, [3:0] = units
//   done_o         high during the cycle whose edge performs the final step
//   acc_o          accumulator value produced by the current step
module bcd_to_bin_serial
  import decimal_entry_accumulator_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [BUF_W-1:0]   bcd_i,
  output logic               done_o,
  output logic [VALUE_W-1:0] acc_o
);

  logic [BUF_W-1:0]   shift_q;
  logic [VALUE_W-1:0] acc_q;
  logic [VALUE_W-1:0] acc_d;
  logic [CNT_W-1:0]   iter_q;
  logic               run_q;
  logic [DIGIT_W-1:0] nibble;

  assign nibble = shift_q[BUF_W-1 -: DIGIT_W];

  // x10 as x8 + x2; a fixed MAX_DIGITS iterations absorbs the leading zeros.
  assign acc_d  = (acc_q << 3) + (acc_q << 1) + {{(VALUE_W-DIGIT_W){1'b0}}, nibble};
  assign acc_o  = acc_d;
  assign done_o = run_q && (iter_q == CNT_W'(MAX_DIGITS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
      run_q   <= 1'b0;
    end else if (clear_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      shift_q <= bcd_i;
      acc_q   <= '0;
      iter_q  <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      acc_q   <= acc_d;
      shift_q <= shift_q << DIGIT_W;
      iter_q  <= iter_q + 1'b1;
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/decimal_entry_accumulator.sv
// rtl/decimal_entry_accumulator.sv - keyed decimal entry buffer with serial binary conversion
// Purpose: collect keyed digits into a live BCD buffer and convert it to a signed binary
//   operand on commit.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_digit_valid    strobe, i_digit is a keyed digit (0..9 legal)
//   i_backspace      strobe, drop last digit
//   i_clear          strobe, clear entry and abort conversion
//   i_sign_toggle    strobe, flip entry sign
//   i_commit         strobe, convert buffer to binary
//   o_digits/o_count/o_entry_sign  live entry state
//   o_value/o_sign/o_valid         converted result and its update pulse
//   o_busy           conversion running
//   o_err            sticky illegal-digit / buffer-full flag
module decimal_entry_accumulator
  import decimal_entry_accumulator_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_digit_valid,
  input  logic [3:0]         i_digit,
  input  logic               i_backspace,
  input  logic               i_clear,
  input  logic               i_sign_toggle,
  input  logic               i_commit,
  output logic [BUF_W-1:0]   o_digits,
  output logic [2:0]         o_count,
  output logic               o_entry_sign,
  output logic [VALUE_W-1:0] o_value,
  output logic               o_sign,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_err
);

  state_e             state_q;
  logic [BUF_W-1:0]   digits_q;
  logic [2:0]         count_q;
  logic               entry_sign_q;
  logic [VALUE_W-1:0] value_q;
  logic               sign_q;
  logic               valid_q;
  logic               busy_q;
  logic               err_q;

  logic               conv_start_d;
  logic               conv_done_d;
  logic [VALUE_W-1:0] conv_acc_d;

  // Clear outranks commit, so a simultaneous pair never starts a conversion.
  assign conv_start_d = (state_q == ST_IDLE) && i_commit && !i_clear;

  bcd_to_bin_serial u_conv (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .start_i (conv_start_d),
    .clear_i (i_clear),
    .bcd_i   (digits_q),
    .done_o  (conv_done_d),
    .acc_o   (conv_acc_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      digits_q     <= '0;
      count_q      <= '0;
      entry_sign_q <= 1'b0;
      value_q      <= '0;
      sign_q       <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_clear) begin
            digits_q     <= '0;
            count_q      <= '0;
            entry_sign_q <= 1'b0;
            err_q        <= 1'b0;
          end else if (i_commit) begin
            state_q <= ST_CONV;
            busy_q  <= 1'b1;
          end else if (i_backspace) begin
            if (count_q != 3'd0) begin
              digits_q <= {{DIGIT_W{1'b0}}, digits_q[BUF_W-1:DIGIT_W]};
              count_q  <= count_q - 3'd1;
            end
          end else if (i_digit_valid) begin
            if (i_digit > DIGIT_MAX || count_q == 3'(MAX_DIGITS)) begin
              err_q <= 1'b1;
            end else if (!(i_digit == 4'd0 && count_q == 3'd0)) begin
              digits_q <= {digits_q[BUF_W-DIGIT_W-1:0], i_digit};
              count_q  <= count_q + 3'd1;
            end
          end else if (i_sign_toggle) begin
            entry_sign_q <= ~entry_sign_q;
          end
        end
        ST_CONV: begin
          if (i_clear) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            digits_q     <= '0;
            count_q      <= '0;
            entry_sign_q <= 1'b0;
            err_q        <= 1'b0;
          end else if (conv_done_d) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            valid_q      <= 1'b1;
            value_q      <= conv_acc_d;
            sign_q       <= entry_sign_q && (conv_acc_d != '0);
            digits_q     <= '0;
            count_q      <= '0;
            entry_sign_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (i_clear) begin
            err_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_digits     = digits_q;
  assign o_count      = count_q;
  assign o_entry_sign = entry_sign_q;
  assign o_value      = value_q;
  assign o_sign       = sign_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;

endmodule
